// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared access-size codes, decode regions and lane helpers for data_memory_unit
package dmem_pkg;

   // funct3 access-size codes (loads and stores share the low encodings)
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [2:0] {
      REGION_MEM,
      REGION_LED,
      REGION_MILLIS,
      REGION_MICROS,
      REGION_NONE
   } region_t;

   typedef logic [3:0] byte_en_t;

   // Lanes touched by a store; halfwords pick their lane pair from off[1] only
   function automatic byte_en_t store_byte_en(input logic [2:0] f3, input logic [1:0] off);
      byte_en_t be;
      be = '0;
      case (f3)
         F3_SB:   be = byte_en_t'(4'b0001 << off);
         F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
         F3_SW:   be = 4'b1111;
         default: be = '0;
      endcase
      return be;
   endfunction

   // Halfword on an odd byte or word off a word boundary
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
      logic mis;
      mis = 1'b0;
      case (f3)
         F3_LH, F3_LHU: mis = off[0];
         F3_LW:         mis = (off != 2'b00);
         default:       mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_timer.sv
// rtl/dmem_timer.sv - free-running microsecond and millisecond counters with their prescalers
module dmem_timer #(
   parameter int CLK_FREQ_HZ = 12_000_000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] millis,
   output logic [31:0] micros
);

   localparam int US_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? (CLK_FREQ_HZ / 1_000_000) : 1;
   localparam int US_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
   localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
   localparam logic [9:0]      MS_LAST = 10'd999;

   logic [US_W-1:0] r_usec_prescaler;
   logic [9:0]      r_msec_prescaler;
   logic [31:0]     r_micros;
   logic [31:0]     r_millis;
   logic            w_us_tick;

   assign w_us_tick = (r_usec_prescaler == US_LAST);
   assign micros    = r_micros;
   assign millis    = r_millis;

   // Clock-cycle prescaler; each wrap is one microsecond
   always_ff @(posedge clk) begin
      if (reset) begin
         r_usec_prescaler <= '0;
         r_micros         <= '0;
      end else if (w_us_tick) begin
         r_usec_prescaler <= '0;
         r_micros         <= r_micros + 32'd1;
      end else begin
         r_usec_prescaler <= r_usec_prescaler + 1'b1;
      end
   end

   // Microsecond-tick prescaler; each wrap is one millisecond
   always_ff @(posedge clk) begin
      if (reset) begin
         r_msec_prescaler <= '0;
         r_millis         <= '0;
      end else if (w_us_tick) begin
         if (r_msec_prescaler == MS_LAST) begin
            r_msec_prescaler <= '0;
            r_millis         <= r_millis + 32'd1;
         end else begin
            r_msec_prescaler <= r_msec_prescaler + 10'd1;
         end
      end
   end

endmodule

// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - unified RV32I memory with LED/timer MMIO; DMEM_MISALIGN_DETECT_EN enables misalignment trapping
module data_memory_unit
   import dmem_pkg::*;
#(
   parameter string       INIT_FILE   = "",
   parameter int          DEPTH_WORDS = 2048,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          CLK_FREQ_HZ = 12_000_000,
   parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFFC,
   parameter logic [31:0] MILLIS_ADDR = 32'hFFFF_FFF8,
   parameter logic [31:0] MICROS_ADDR = 32'hFFFF_FFF4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  funct3,
   input  logic        write_mem,
   input  logic [31:0] write_address,
   input  logic [31:0] write_data,
   input  logic [31:0] read_address,
   output logic [31:0] read_data,
   output logic [7:0]  led,
   output logic [31:0] millis,
   output logic [31:0] micros,
   output logic        misaligned_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic [31:0]      r_mem [DEPTH_WORDS];
   logic [31:0]      r_read_data;
   logic [7:0]       r_led;

   logic [31:0]      w_rd_offset;
   logic [IDX_W-1:0] w_rd_index;
   logic [1:0]       w_rd_off;
   region_t          w_rd_region;
   logic [31:0]      w_rd_word;
   logic [7:0]       w_rd_byte;
   logic [15:0]      w_rd_half;
   logic [31:0]      w_rd_value;
   logic             w_rd_mis;

   logic [31:0]      w_wr_offset;
   logic [IDX_W-1:0] w_wr_index;
   logic [1:0]       w_wr_off;
   region_t          w_wr_region;
   byte_en_t         w_wr_be;
   logic [31:0]      w_wr_lanes;
   logic             w_wr_mis;
   logic             w_mem_we;
   logic             w_led_we;

   // MMIO words win over the array; offset bits never matter for MMIO
   function automatic region_t decode(input logic [29:0] word_addr, input logic in_mem);
      region_t region;
      if (word_addr == LED_ADDR[31:2])         region = REGION_LED;
      else if (word_addr == MILLIS_ADDR[31:2]) region = REGION_MILLIS;
      else if (word_addr == MICROS_ADDR[31:2]) region = REGION_MICROS;
      else if (in_mem)                         region = REGION_MEM;
      else                                     region = REGION_NONE;
      return region;
   endfunction

   dmem_timer #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .millis (millis),
      .micros (micros)
   );

   // Address arithmetic relative to the array base; below-base addresses wrap high and fall out of range
   assign w_rd_offset = read_address - BASE_ADDR;
   assign w_rd_index  = w_rd_offset[IDX_W+1:2];
   assign w_rd_off    = w_rd_offset[1:0];
   assign w_rd_region = decode(read_address[31:2], (w_rd_offset[31:IDX_W+2] == '0));

   assign w_wr_offset = write_address - BASE_ADDR;
   assign w_wr_index  = w_wr_offset[IDX_W+1:2];
   assign w_wr_off    = w_wr_offset[1:0];
   assign w_wr_region = decode(write_address[31:2], (w_wr_offset[31:IDX_W+2] == '0));

`ifdef DMEM_MISALIGN_DETECT_EN
   logic r_misaligned;

   assign w_rd_mis = is_misaligned(funct3, w_rd_off);
   assign w_wr_mis = write_mem & is_misaligned(funct3, w_wr_off);
   assign misaligned_error = r_misaligned;

   // Sticky flag: any misaligned load or store latches it until reset
   always_ff @(posedge clk) begin
      if (reset) r_misaligned <= 1'b0;
      else       r_misaligned <= r_misaligned | w_rd_mis | w_wr_mis;
   end
`else
   assign w_rd_mis = 1'b0;
   assign w_wr_mis = 1'b0;
   assign misaligned_error = 1'b0;
`endif

   // Load path: select the word, right-justify the addressed byte/half, or return MMIO state
   always_comb begin
      w_rd_value = '0;
      w_rd_word  = r_mem[w_rd_index];
      case (w_rd_off)
         2'd0:    w_rd_byte = w_rd_word[7:0];
         2'd1:    w_rd_byte = w_rd_word[15:8];
         2'd2:    w_rd_byte = w_rd_word[23:16];
         default: w_rd_byte = w_rd_word[31:24];
      endcase
      w_rd_half = w_rd_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (w_rd_region)
         REGION_MEM: begin
            case (funct3)
               F3_LB, F3_LBU: w_rd_value = {24'h0, w_rd_byte};
               F3_LH, F3_LHU: w_rd_value = {16'h0, w_rd_half};
               F3_LW:         w_rd_value = w_rd_word;
               default:       w_rd_value = '0;
            endcase
         end
         REGION_LED:    w_rd_value = {24'h0, r_led};
         REGION_MILLIS: w_rd_value = millis;
         REGION_MICROS: w_rd_value = micros;
         default:       w_rd_value = '0;
      endcase
      if (w_rd_mis) w_rd_value = '0;
   end

   // Store path: replicate data across lanes so byte enables alone pick the destination
   always_comb begin
      w_wr_lanes = write_data;
      case (funct3)
         F3_SB:   w_wr_lanes = {4{write_data[7:0]}};
         F3_SH:   w_wr_lanes = {2{write_data[15:0]}};
         default: w_wr_lanes = write_data;
      endcase
      w_wr_be  = w_wr_mis ? byte_en_t'(4'b0000) : store_byte_en(funct3, w_wr_off);
      w_mem_we = write_mem & ~reset & (w_wr_region == REGION_MEM);
      w_led_we = write_mem & ~w_wr_mis & (w_wr_region == REGION_LED)
               & ((funct3 == F3_SB) | (funct3 == F3_SW));
   end

   // Array write; contents survive reset and a store coinciding with reset is dropped
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wr_be[b]) r_mem[w_wr_index][8*b +: 8] <= w_wr_lanes[8*b +: 8];
         end
      end
   end

   // Registered load result; sampling the old word gives read-before-write on collisions
   always_ff @(posedge clk) begin
      if (reset) r_read_data <= '0;
      else       r_read_data <= w_rd_value;
   end

   // LED register, updated only by byte and word stores
   always_ff @(posedge clk) begin
      if (reset)         r_led <= '0;
      else if (w_led_we) r_led <= write_data[7:0];
   end

   assign read_data = r_read_data;
   assign led       = r_led;

endmodule
